// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the load/store RAM sequencer.
//   state_t     : FSM state encoding (3 bits)
//   *_DEF       : default address/data widths and RAM read latency
//   cnt_width() : width of the read-latency counter for a given latency
package mem_access_ctrl_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;
   localparam int RD_LAT_DEF = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      RESP   = 3'd2,
      WR     = 3'd3,
      RMW_RD = 3'd4,
      RMW_WR = 3'd5
   } state_t;

   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_be_merge.sv
// Combinational byte-lane merge: each byte of merged comes from new_word when
// its byte enable is set, otherwise from old_word.
//   old_word in  DATA_W    word currently in RAM
//   new_word in  DATA_W    store data
//   be       in  DATA_W/8  byte enables
//   merged   out DATA_W    merged word
module be_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_word,
   input  logic [DATA_W-1:0]   new_word,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   merged
);

   for (genvar i = 0; i < DATA_W/8; i++) begin : g_lane
      assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for a single-port word RAM. Takes one load/store at
// a time over valid/ready, drives RAM strobes from registers only, does
// byte-masked stores as read-modify-write and returns load data over a
// valid/ready response channel.
//   clk, rst_n              clock, async active-low reset
//   req_valid/ready         request handshake
//   req_we/addr/wdata/be    request payload (be ignored for loads)
//   rsp_valid/ready/rdata   load response
//   mem_address/data_in     registered RAM address and write data
//   mem_we/mem_re           RAM strobes, never high together
//   mem_data_out            RAM read data
//   busy                    FSM not idle
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_data_in,
   output logic                mem_we,
   output logic                mem_re,
   input  logic [DATA_W-1:0]   mem_data_out,
   output logic                busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = cnt_width(RD_LAT);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BE_W-1:0]   be_r;
   logic [DATA_W-1:0] merged;
   logic              rd_last;

   // Gating with rst_n keeps ready low for the whole reset window, not just
   // until the state register is forced.
   assign req_ready = (state == IDLE) && rst_n;
   assign busy      = (state != IDLE);
   assign rd_last   = (cnt == CNT_W'(RD_LAT - 1));

   // During RMW_RD mem_data_in still holds the captured store data.
   be_merge #(.DATA_W(DATA_W)) u_merge (
      .old_word (mem_data_out),
      .new_word (mem_data_in),
      .be       (be_r),
      .merged   (merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         be_r        <= '0;
         mem_address <= '0;
         mem_data_in <= '0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_address <= req_addr;
                  mem_data_in <= req_wdata;
                  be_r        <= req_be;
                  cnt         <= '0;
                  if (!req_we) begin
                     state  <= RD;
                     mem_re <= 1'b1;
                  end else if (&req_be) begin
                     state  <= WR;
                     mem_we <= 1'b1;
                  end else if (|req_be) begin
                     state  <= RMW_RD;
                     mem_re <= 1'b1;
                  end
                  // be == 0: accepted as a no-op, stay idle
               end
            end
            RD, RMW_RD: begin
               if (rd_last) begin
                  mem_re <= 1'b0;
                  cnt    <= '0;
                  if (state == RD) begin
                     rsp_rdata <= mem_data_out;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     // Data changes here while we is still low, so the
                     // level-sensitive RAM never sees it mid-write.
                     mem_data_in <= merged;
                     mem_we      <= 1'b1;
                     state       <= RMW_WR;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            WR, RMW_WR: begin
               mem_we <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small behavioural RAM
// (combinational read, write on clock edge while we is high).
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic [7:0]  mem_address;
   logic [31:0] mem_data_in;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_data_out;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] ram [0:255];
   int we_pulses = 0;
   int re_cycles = 0;
   int overlap   = 0;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_be       (req_be),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_data_out (mem_data_out),
      .busy         (busy)
   );

   assign mem_data_out = mem_re ? ram[mem_address] : 32'h0;

   always @(posedge clk) begin
      if (mem_we) ram[mem_address] <= mem_data_in;
      if (mem_we) we_pulses <= we_pulses + 1;
      if (mem_re) re_cycles <= re_cycles + 1;
      if (mem_we && mem_re) overlap <= overlap + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Present a request at a negedge, hold until accepted (bounded), then drop
   // valid just after the accepting edge.
   task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be);
      int waited;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   initial begin
      int we0, re0;

      // 1: reset
      #1 rst_n = 1'b0;
      #2;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_mem_we",    {31'b0, mem_we},    32'd0);
      chk("rst_mem_re",    {31'b0, mem_re},    32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_busy",      {31'b0, busy},      32'd0);
      chk("rst_addr",      {24'b0, mem_address}, 32'd0);
      chk("rst_rdata",     rsp_rdata,          32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

      // 2: full store, then load back
      we0 = we_pulses;
      send(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
      @(negedge clk);   // +1
      chk("st_we",      {31'b0, mem_we}, 32'd1);
      chk("st_addr",    {24'b0, mem_address}, 32'h10);
      chk("st_data",    mem_data_in, 32'hDEADBEEF);
      chk("st_ready_lo", {31'b0, req_ready}, 32'd0);
      chk("st_busy",    {31'b0, busy}, 32'd1);
      @(negedge clk);   // +2
      chk("st_we_off",  {31'b0, mem_we}, 32'd0);
      chk("st_ready_hi", {31'b0, req_ready}, 32'd1);
      chk("st_one_pulse", we_pulses - we0, 32'd1);

      send(1'b0, 8'h10, 32'h0, 4'h0);
      @(negedge clk);   // +1
      chk("ld_re",      {31'b0, mem_re}, 32'd1);
      chk("ld_rv_early", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);   // +2
      chk("ld_rv",      {31'b0, rsp_valid}, 32'd1);
      chk("ld_rdata",   rsp_rdata, 32'hDEADBEEF);
      chk("ld_re_off",  {31'b0, mem_re}, 32'd0);
      @(negedge clk);
      chk("ld_rv_done", {31'b0, rsp_valid}, 32'd0);
      chk("ld_ready",   {31'b0, req_ready}, 32'd1);

      // 3: partial store as read-modify-write
      send(1'b1, 8'h20, 32'h11223344, 4'hF);
      @(negedge clk); @(negedge clk);
      we0 = we_pulses; re0 = re_cycles;
      send(1'b1, 8'h20, 32'h0000AA00, 4'b0010);
      @(negedge clk);   // +1
      chk("rmw_re",     {31'b0, mem_re}, 32'd1);
      chk("rmw_we_lo",  {31'b0, mem_we}, 32'd0);
      @(negedge clk);   // +2
      chk("rmw_we",     {31'b0, mem_we}, 32'd1);
      chk("rmw_re_off", {31'b0, mem_re}, 32'd0);
      chk("rmw_data",   mem_data_in, 32'h1122AA44);
      @(negedge clk);   // +3
      chk("rmw_ready",  {31'b0, req_ready}, 32'd1);
      chk("rmw_ram",    ram[8'h20], 32'h1122AA44);
      chk("rmw_we_cnt", we_pulses - we0, 32'd1);
      chk("rmw_re_cnt", re_cycles - re0, 32'd1);

      // 4: response backpressure with a pending request, then reset mid-cycle
      rsp_ready = 1'b0;
      send(1'b0, 8'h10, 32'h0, 4'h0);
      @(negedge clk); @(negedge clk);
      chk("bp_rv", {31'b0, rsp_valid}, 32'd1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40;
      req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      we0 = we_pulses;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_rv",    {31'b0, rsp_valid}, 32'd1);
         chk("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("bp_hold_ready", {31'b0, req_ready}, 32'd0);
      end
      chk("bp_no_accept", we_pulses - we0, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rv",    {31'b0, rsp_valid}, 32'd0);
      chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
      chk("mid_rst_busy",  {31'b0, busy}, 32'd0);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_rel", {31'b0, req_ready}, 32'd1);

      // 5: store with no byte enables is a no-op
      send(1'b1, 8'h30, 32'h55AA55AA, 4'hF);
      @(negedge clk); @(negedge clk);
      we0 = we_pulses; re0 = re_cycles;
      send(1'b1, 8'h30, 32'h00000000, 4'h0);
      @(negedge clk);   // +1
      chk("be0_ready", {31'b0, req_ready}, 32'd1);
      chk("be0_busy",  {31'b0, busy}, 32'd0);
      chk("be0_we",    we_pulses - we0, 32'd0);
      chk("be0_re",    re_cycles - re0, 32'd0);
      chk("be0_ram",   ram[8'h30], 32'h55AA55AA);

      // 6: reset during RMW_RD
      we0 = we_pulses;
      send(1'b1, 8'h30, 32'h000000FF, 4'b0001);
      @(negedge clk);   // +1, in RMW_RD
      chk("r6_re", {31'b0, mem_re}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("r6_re_drop", {31'b0, mem_re}, 32'd0);
      chk("r6_we",      {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("r6_no_we",  we_pulses - we0, 32'd0);
      chk("r6_ram",    ram[8'h30], 32'h55AA55AA);
      chk("r6_idle",   {31'b0, busy}, 32'd0);
      chk("r6_ready",  {31'b0, req_ready}, 32'd1);

      chk("no_overlap", overlap, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
